ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
Iterative RV32M/RV64M multiply/divide unit that sits beside the ex stage. ex issues one M-extension operation with decoded operands. The unit stalls the pipeline through hold_ctrl while it computes. It returns the rd write-back triple (we/addr/data) on completion. Width is parametrised, and operand signedness is selected per operation.

Parameters:
XLEN, 32, operand/result width (32 or 64)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-low reset
i_start  input  1  issue request; sampled only in IDLE
i_op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
i_rs1_data  input  XLEN  operand A (dividend / multiplicand)
i_rs2_data  input  XLEN  operand B (divisor / multiplier)
i_regd_addr  input  5  destination register
i_flush  input  1  abort in-flight op (jump/trap)
o_busy  output  1  state != IDLE
o_hold_req  output  1  stall request to hold_ctrl
o_regd_we  output  1  one-cycle write-back strobe
o_regd_w_addr  output  5  rd address, valid with o_regd_we
o_regd_w_data  output  XLEN  result, valid with o_regd_we

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE; all outputs 0; accumulators, counter and latched operands 0.
- State machine: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - On i_start & !i_flush, latch op, rd and |operands|. Record the result sign per op: MULH signed×signed, MULHSU signed×unsigned, DIV/REM signed.
  - Load counter=XLEN and go to CALC.
- CALC, one bit per cycle; counter decrements; exit to DONE when counter reaches 1.
  - Multiply: shift-add on a 2·XLEN product.
  - Divide: restoring divide; quotient and remainder registers are each XLEN wide.
- DONE (one cycle):
  - Apply sign correction: two's-complement negate of the product if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Select the low XLEN bits for MUL, the high XLEN bits for MULH*, the quotient or the remainder.
  - Drive o_regd_we=1 with addr/data, then return to IDLE.
- Latency: accept edge at cycle 0; o_regd_we high in cycle XLEN+1. Back-to-back: a new i_start is accepted in the cycle after DONE.
- Special cases skip CALC (IDLE -> DONE, o_regd_we in cycle 1):
  - divisor 0: DIV/DIVU -> all ones; REM/REMU -> dividend.
  - signed overflow (dividend = -2^(XLEN-1), divisor = -1): DIV -> dividend; REM -> 0.
- o_hold_req = i_start in IDLE, or state==CALC, or state==DONE. The issuing instruction is therefore held from its first cycle, and released when write-back occurs.
- i_start while busy: ignored.
- i_flush in CALC or DONE:
  - next state IDLE; o_regd_we forced 0 in that cycle; no write-back.
  - i_flush and i_start together in IDLE: start not accepted.
- Reset mid-operation: immediate return to IDLE; no write-back.
- All arithmetic is unsigned on magnitudes; signs are handled only at load and in DONE.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: multiply ops bypass CALC. The product is computed in IDLE -> DONE with a single-cycle XLEN×XLEN multiplier (with sign extension to XLEN+1 bits), so o_regd_we fires in cycle 1. Divide ops are unchanged.
- Undefined: all multiplies use the iterative path (XLEN+1 latency); no hardware multiplier is inferred.

Decomposition:
- Shared defines include: the op encodings (MULDIV_MUL..MULDIV_REMU), the state encodings (IDLE/CALC/DONE), and RegsAddrBus reuse.
- One sub-module, muldiv_negate: a parametrised-width conditional two's-complement. It is instantiated for operand magnitude extraction and for result sign correction.

Test Plan:
- MUL 7×6 (XLEN=32) -> o_regd_we pulses exactly at cycle 33, data 42, addr echoed. o_hold_req is high from the i_start cycle through cycle 33 and low in cycle 34.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF(-1)×0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV x/0 -> 0xFFFFFFFF and REM x/0 -> x, both in cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0, both in cycle 1.
- Flush at cycle 10 of a DIVU -> no o_regd_we; o_busy=0 next cycle; a new i_start the following cycle completes correctly.
- Async reset asserted mid-CALC, between clock edges -> outputs 0 immediately. A second i_start while busy -> ignored, only one write-back. With MULDIV_FAST_MUL_EN: MUL 3×5 -> 15 in cycle 1.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared definitions for the RV32M/RV64M multiply/divide unit.
//   - op_e      : M-extension funct3 encodings (MULDIV_MUL .. MULDIV_REMU)
//   - state_e   : sequencer states (IDLE / CALC / DONE)
//   - regs_addr_t / REGS_ADDR_W : register-file address bus, reused for rd
//   - is_div()  : true for the four divide/remainder encodings
package ex_muldiv_pkg;

    localparam int REGS_ADDR_W = 5;
    typedef logic [REGS_ADDR_W-1:0] regs_addr_t;

    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'd0,
        MULDIV_MULH   = 3'd1,
        MULDIV_MULHSU = 3'd2,
        MULDIV_MULHU  = 3'd3,
        MULDIV_DIV    = 3'd4,
        MULDIV_DIVU   = 3'd5,
        MULDIV_REM    = 3'd6,
        MULDIV_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_div(input op_e op);
        return (op == MULDIV_DIV) || (op == MULDIV_DIVU) ||
               (op == MULDIV_REM) || (op == MULDIV_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: issue / write-back bundle between the ex stage and ex_muldiv.
//   Issue    (ex -> unit): i_start, i_op, i_rs1_data, i_rs2_data, i_regd_addr, i_flush
//   Status   (unit -> ex): o_busy, o_hold_req
//   Writeback(unit -> ex): o_regd_we, o_regd_w_addr, o_regd_w_data
// Modports: master = ex stage side, slave = multiply/divide unit side.
interface ex_muldiv_if
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
);
    logic             i_start;
    logic [2:0]       i_op;
    logic [XLEN-1:0]  i_rs1_data;
    logic [XLEN-1:0]  i_rs2_data;
    regs_addr_t       i_regd_addr;
    logic             i_flush;
    logic             o_busy;
    logic             o_hold_req;
    logic             o_regd_we;
    regs_addr_t       o_regd_w_addr;
    logic [XLEN-1:0]  o_regd_w_data;

    modport master (
        output i_start, i_op, i_rs1_data, i_rs2_data, i_regd_addr, i_flush,
        input  o_busy, o_hold_req, o_regd_we, o_regd_w_addr, o_regd_w_data
    );

    modport slave (
        input  i_start, i_op, i_rs1_data, i_rs2_data, i_regd_addr, i_flush,
        output o_busy, o_hold_req, o_regd_we, o_regd_w_addr, o_regd_w_data
    );
endinterface

// File: rtl/ex_muldiv_negate.sv
// muldiv_negate: conditional two's-complement of a W-bit value.
//   en   : 1 -> dout = -din, 0 -> dout = din
//   din  : W-bit input
//   dout : W-bit output
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    assign dout = en ? (~din + W'(1)) : din;
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M/RV64M multiply/divide unit beside the ex stage.
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : ex_muldiv_if.slave (issue, flush, busy/hold, rd write-back)
// One bit per cycle in CALC (shift-add multiply, restoring divide) on operand
// magnitudes; signs are applied when the result is presented in DONE.
// Divide by zero and signed overflow skip CALC and write back one cycle after
// acceptance.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// multiplier and also skip CALC; divides are unchanged.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       i_clk,
    input  logic       i_reset,
    ex_muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    state_e            state, state_nxt;
    op_e               op_q;
    regs_addr_t        rd_q;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   a_q, b_q;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;
    logic              neg_res, neg_rem;
    logic              spec_q;
    logic [XLEN-1:0]   spec_res;

    // Issue-side decode
    op_e               op_in;
    logic              sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, accept, special;
    logic [XLEN-1:0]   spec_val;

    assign op_in  = op_e'(bus.i_op);
    assign sgn_a  = (op_in == MULDIV_MULH) || (op_in == MULDIV_MULHSU) ||
                    (op_in == MULDIV_DIV)  || (op_in == MULDIV_REM);
    assign sgn_b  = (op_in == MULDIV_MULH) || (op_in == MULDIV_DIV) ||
                    (op_in == MULDIV_REM);
    assign a_neg  = sgn_a & bus.i_rs1_data[XLEN-1];
    assign b_neg  = sgn_b & bus.i_rs2_data[XLEN-1];
    assign accept = (state == IDLE) && bus.i_start && !bus.i_flush;

    muldiv_negate #(.W(XLEN)) u_mag_a (.en(a_neg), .din(bus.i_rs1_data), .dout(a_mag));
    muldiv_negate #(.W(XLEN)) u_mag_b (.en(b_neg), .din(bus.i_rs2_data), .dout(b_mag));

    assign div_zero = (bus.i_rs2_data == '0);
    assign div_ovf  = ((op_in == MULDIV_DIV) || (op_in == MULDIV_REM)) &&
                      (bus.i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (bus.i_rs2_data == '1);
    assign special  = is_div(op_in) && (div_zero || div_ovf);

    always_comb begin
        spec_val = '0;
        if (div_zero) begin
            spec_val = ((op_in == MULDIV_DIV) || (op_in == MULDIV_DIVU)) ? '1 : bus.i_rs1_data;
        end else if (op_in == MULDIV_DIV) begin
            spec_val = bus.i_rs1_data;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic        [2*XLEN-1:0] fast_prod;

    assign fast_a    = {a_neg, bus.i_rs1_data};
    assign fast_b    = {b_neg, bus.i_rs2_data};
    assign fast_prod = $signed({{(XLEN-1){fast_a[XLEN]}}, fast_a}) *
                       $signed({{(XLEN-1){fast_b[XLEN]}}, fast_b});
`endif

    // One iteration step for each algorithm
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step;
    logic [XLEN:0]     div_shift, div_diff;
    logic [XLEN-1:0]   quot_step, rem_step;

    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_q} : '0);
        prod_step = {mul_sum, prod[XLEN-1:1]};
        div_shift = {rem, quot[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        // Restore (keep the shifted remainder) when the trial subtract borrows
        if (div_diff[XLEN]) begin
            rem_step  = div_shift[XLEN-1:0];
            quot_step = {quot[XLEN-2:0], 1'b0};
        end else begin
            rem_step  = div_diff[XLEN-1:0];
            quot_step = {quot[XLEN-2:0], 1'b1};
        end
    end

    // Sequencer
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_nxt = DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!is_div(op_in)) begin
                        state_nxt = DONE;
`endif
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.i_flush)              state_nxt = IDLE;
                else if (cnt == CNT_W'(1))    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch and iteration datapath
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            op_q     <= MULDIV_MUL;
            rd_q     <= '0;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod     <= '0;
            quot     <= '0;
            rem      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            spec_q   <= 1'b0;
            spec_res <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= op_in;
                        rd_q     <= bus.i_regd_addr;
                        cnt      <= CNT_W'(XLEN);
                        a_q      <= a_mag;
                        b_q      <= b_mag;
                        quot     <= a_mag;
                        rem      <= '0;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        spec_q   <= special;
                        spec_res <= spec_val;
`ifdef MULDIV_FAST_MUL_EN
                        // Fast product is already signed; no correction in DONE
                        if (!is_div(op_in)) begin
                            prod    <= fast_prod;
                            neg_res <= 1'b0;
                        end else begin
                            prod    <= {{XLEN{1'b0}}, b_mag};
                        end
`else
                        prod     <= {{XLEN{1'b0}}, b_mag};
`endif
                    end
                end
                CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (is_div(op_q)) begin
                        quot <= quot_step;
                        rem  <= rem_step;
                    end else begin
                        prod <= prod_step;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result sign correction and selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_sel, div_fix, result;
    logic              div_is_quot;

    assign div_is_quot = (op_q == MULDIV_DIV) || (op_q == MULDIV_DIVU);
    assign div_sel     = div_is_quot ? quot : rem;

    muldiv_negate #(.W(2*XLEN)) u_fix_prod (.en(neg_res), .din(prod), .dout(prod_fix));
    // Quotient follows the operand sign difference; remainder follows the dividend
    muldiv_negate #(.W(XLEN)) u_fix_div (
        .en  (div_is_quot ? neg_res : neg_rem),
        .din (div_sel),
        .dout(div_fix)
    );

    always_comb begin
        if (spec_q)                  result = spec_res;
        else if (is_div(op_q))       result = div_fix;
        else if (op_q == MULDIV_MUL) result = prod_fix[XLEN-1:0];
        else                         result = prod_fix[2*XLEN-1:XLEN];
    end

    logic we;
    assign we                = (state == DONE) && !bus.i_flush;
    assign bus.o_regd_we     = we;
    assign bus.o_regd_w_addr = we ? rd_q : '0;
    assign bus.o_regd_w_data = we ? result : '0;
    assign bus.o_busy        = (state != IDLE);
    assign bus.o_hold_req    = ((state == IDLE) && bus.i_start) ||
                               (state == CALC) || (state == DONE);

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vector table plus hand-written sequences for flush,
// asynchronous reset and issue-while-busy on the 32-bit ex_muldiv.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    ex_muldiv_if #(.XLEN(XLEN)) bus ();

    ex_muldiv #(.XLEN(XLEN)) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.i_start     = 1'b1;
        bus.i_op        = op;
        bus.i_rs1_data  = a;
        bus.i_rs2_data  = b;
        bus.i_regd_addr = rd;
    endtask

    // Issue one op, then watch for the write-back within a bounded window.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat,
                          input string nm);
        int  cyc;
        bit  seen;
        bit  hold_ok;
        @(negedge clk);
        drive(op, a, b, rd);
        #1;
        check({nm, "_hold_c0"}, 64'(bus.o_hold_req), 64'(1));
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        seen    = 1'b0;
        hold_ok = 1'b1;
        cyc     = 0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(negedge clk);
            if (bus.o_hold_req !== 1'b1) hold_ok = 1'b0;
            if (bus.o_regd_we === 1'b1) begin
                seen = 1'b1;
                cyc  = c;
                check({nm, "_data"}, 64'(bus.o_regd_w_data), 64'(exp));
                check({nm, "_addr"}, 64'(bus.o_regd_w_addr), 64'(rd));
            end
        end
        check({nm, "_seen"}, 64'(seen), 64'(1));
        check({nm, "_latency"}, 64'(cyc), 64'(lat));
        check({nm, "_hold_busy"}, 64'(hold_ok), 64'(1));
        @(negedge clk);
        check({nm, "_we_after"}, 64'(bus.o_regd_we), 64'(0));
        check({nm, "_hold_after"}, 64'(bus.o_hold_req), 64'(0));
        check({nm, "_busy_after"}, 64'(bus.o_busy), 64'(0));
    endtask

    initial begin
        int we_cnt;
        logic [31:0] last_data;
        logic [4:0]  last_addr;

        bus.i_start     = 1'b0;
        bus.i_op        = 3'd0;
        bus.i_rs1_data  = '0;
        bus.i_rs2_data  = '0;
        bus.i_regd_addr = '0;
        bus.i_flush     = 1'b0;
        rst_n           = 1'b1;
        #2 rst_n = 1'b0;
        #25;
        check("rst_busy", 64'(bus.o_busy), 64'(0));
        check("rst_hold", 64'(bus.o_hold_req), 64'(0));
        check("rst_we",   64'(bus.o_regd_we), 64'(0));
        check("rst_addr", 64'(bus.o_regd_w_addr), 64'(0));
        check("rst_data", 64'(bus.o_regd_w_data), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{MULDIV_MUL,    32'd7,        32'd6,        5'd3,  32'd42,       MUL_LAT, "mul_7x6"});
        vecs.push_back('{MULDIV_MULH,   32'h80000000, 32'h80000000, 5'd4,  32'h40000000, MUL_LAT, "mulh_min"});
        vecs.push_back('{MULDIV_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFF, MUL_LAT, "mulhsu_m1"});
        vecs.push_back('{MULDIV_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, MUL_LAT, "mulhu_max"});
        vecs.push_back('{MULDIV_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000001, MUL_LAT, "mul_max"});
        vecs.push_back('{MULDIV_MULH,   32'hFFFFFFFD, 32'd5,        5'd8,  32'hFFFFFFFF, MUL_LAT, "mulh_m3x5"});
        vecs.push_back('{MULDIV_MULHSU, 32'd2,        32'h80000000, 5'd9,  32'h00000001, MUL_LAT, "mulhsu_2"});
        vecs.push_back('{MULDIV_MUL,    32'd3,        32'd5,        5'd10, 32'd15,       MUL_LAT, "mul_3x5"});
        vecs.push_back('{MULDIV_DIV,    32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFD, DIV_LAT, "div_m7_2"});
        vecs.push_back('{MULDIV_REM,    32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFF, DIV_LAT, "rem_m7_2"});
        vecs.push_back('{MULDIV_DIV,    32'd7,        32'hFFFFFFFE, 5'd13, 32'hFFFFFFFD, DIV_LAT, "div_7_m2"});
        vecs.push_back('{MULDIV_REM,    32'd7,        32'hFFFFFFFE, 5'd14, 32'd1,        DIV_LAT, "rem_7_m2"});
        vecs.push_back('{MULDIV_DIVU,   32'd100,      32'd7,        5'd15, 32'd14,       DIV_LAT, "divu_100_7"});
        vecs.push_back('{MULDIV_REMU,   32'd100,      32'd7,        5'd16, 32'd2,        DIV_LAT, "remu_100_7"});
        vecs.push_back('{MULDIV_DIV,    32'd1234,     32'd0,        5'd17, 32'hFFFFFFFF, 1,       "div_by0"});
        vecs.push_back('{MULDIV_REM,    32'd1234,     32'd0,        5'd18, 32'd1234,     1,       "rem_by0"});
        vecs.push_back('{MULDIV_DIVU,   32'd5,        32'd0,        5'd19, 32'hFFFFFFFF, 1,       "divu_by0"});
        vecs.push_back('{MULDIV_REMU,   32'd5,        32'd0,        5'd20, 32'd5,        1,       "remu_by0"});
        vecs.push_back('{MULDIV_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 1,       "div_ovf"});
        vecs.push_back('{MULDIV_REM,    32'h80000000, 32'hFFFFFFFF, 5'd22, 32'd0,        1,       "rem_ovf"});
        vecs.push_back('{MULDIV_DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd23, 32'd0,        DIV_LAT, "divu_big"});

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat, vecs[i].nm);

        // Flush during CALC of a DIVU, then an immediate new op
        @(negedge clk);
        drive(MULDIV_DIVU, 32'd100, 32'd7, 5'd24);
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        we_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 10) begin
                bus.i_flush = 1'b1;
                #1;
            end
            if (bus.o_regd_we === 1'b1) we_cnt++;
        end
        @(posedge clk);
        #1 bus.i_flush = 1'b0;
        @(negedge clk);
        if (bus.o_regd_we === 1'b1) we_cnt++;
        check("flush_no_we", 64'(we_cnt), 64'(0));
        check("flush_busy",  64'(bus.o_busy), 64'(0));
        run_op(MULDIV_DIVU, 32'd100, 32'd7, 5'd25, 32'd14, DIV_LAT, "after_flush");

        // Asynchronous reset between clock edges during CALC
        @(negedge clk);
        drive(MULDIV_DIVU, 32'd100, 32'd7, 5'd26);
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 64'(bus.o_busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.o_busy), 64'(0));
        check("arst_hold", 64'(bus.o_hold_req), 64'(0));
        check("arst_we",   64'(bus.o_regd_we), 64'(0));
        check("arst_data", 64'(bus.o_regd_w_data), 64'(0));
        #1 rst_n = 1'b1;
        we_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.o_regd_we === 1'b1) we_cnt++;
        end
        check("arst_no_we", 64'(we_cnt), 64'(0));

        // Second i_start while busy must be ignored
        @(negedge clk);
        drive(MULDIV_DIVU, 32'd100, 32'd7, 5'd9);
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        we_cnt    = 0;
        last_data = '0;
        last_addr = '0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 5) drive(MULDIV_MUL, 32'd3, 32'd5, 5'd10);
            if (c == 6) bus.i_start = 1'b0;
            if (bus.o_regd_we === 1'b1) begin
                we_cnt++;
                last_data = bus.o_regd_w_data;
                last_addr = bus.o_regd_w_addr;
            end
        end
        check("busy_start_wb_count", 64'(we_cnt), 64'(1));
        check("busy_start_data",     64'(last_data), 64'(14));
        check("busy_start_addr",     64'(last_addr), 64'(9));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
